// File: rtl/divclk_pkg.sv
// Shared definitions for the divided-clock monitor: FSM encoding and defaults.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package divclk_pkg;

    // Half-cycle counter width and settle length used when the parent does not override.
    localparam int CNT_W_DEF  = 6;
    localparam int SETTLE_DEF = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_MEASURE = 2'd2,
        ST_STALL   = 2'd3
    } mon_state_t;

endpackage

// File: rtl/dual_edge_sampler.sv
// Samples div_in on both clk edges and presents the pair, retimed to the rising edge.
// Latency: s_pos is div_in from the last rising edge, s_neg from the falling edge before it.
// Backpressure: none; one sample pair is produced every clk.
//
// Ports: clk, rst_n (async active-low, already release-synchronised)
//        div_in (divided clock), s_neg / s_pos (ordered sample pair, s_neg older)
module dual_edge_sampler (
    input  logic clk,
    input  logic rst_n,
    input  logic div_in,
    output logic s_neg,
    output logic s_pos
);

    logic neg_raw;

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_raw <= 1'b0;
        end else begin
            neg_raw <= div_in;
        end
    end

    // Re-register the falling-edge sample so both halves of the pair change together
    // on the rising edge; neg_raw was taken half a cycle before div_in is sampled here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_neg <= 1'b0;
            s_pos <= 1'b0;
        end else begin
            s_neg <= neg_raw;
            s_pos <= div_in;
        end
    end

endmodule

// File: rtl/divclk_monitor.sv
// Measures period and high time of a divided clock at half-cycle resolution and checks them against N.
// Latency: results appear one clk after the rising edge that processes the closing div_in edge.
// Backpressure: none; meas_valid is a single-cycle pulse that is not held.
//
// Ports: clk, reset (async active-low), div_in, exp_mod (expected N, 2..15)
//        period_hc / high_hc (last measurement in half-cycles), meas_valid (update pulse)
//        period_ok / duty_ok (compare against 2N / N), timeout, cfg_err, err_sticky
module divclk_monitor
    import divclk_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,  // must be >= 5 so that 2*15 fits
    parameter int SETTLE = SETTLE_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             div_in,
    input  logic [3:0]       exp_mod,
    output logic [CNT_W-1:0] period_hc,
    output logic [CNT_W-1:0] high_hc,
    output logic             meas_valid,
    output logic             period_ok,
    output logic             duty_ok,
    output logic             timeout,
    output logic             cfg_err,
    output logic             err_sticky
);

    localparam logic [CNT_W-1:0] CNT_SAT  = '1;
    localparam logic [CNT_W:0]   CNT_STEP = {{(CNT_W-1){1'b0}}, 2'b10};
    localparam logic [7:0]       SETTLE_L = 8'(SETTLE);

    // Reset assertion is immediate; release is delayed by two clk edges.
    logic [1:0] rst_sync;
    logic       rst_n;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n = rst_sync[1];

    logic s_neg;
    logic s_pos;

    dual_edge_sampler u_sampler (
        .clk    (clk),
        .rst_n  (rst_n),
        .div_in (div_in),
        .s_neg  (s_neg),
        .s_pos  (s_pos)
    );

    mon_state_t       state;
    logic [CNT_W-1:0] per_cnt;
    logic [CNT_W-1:0] high_cnt;
    logic [7:0]       settle_cnt;
    logic             prev_pos;
    logic [3:0]       exp_q;
    logic             period_ok_q;
    logic             duty_ok_q;

    logic             rise_neg;
    logic             rise_pos;
    logic             rise;
    logic [CNT_W:0]   per_sum;
    logic [CNT_W:0]   high_sum;
    logic [CNT_W-1:0] per_adv;
    logic [CNT_W-1:0] high_adv;
    logic [CNT_W-1:0] per_restart;
    logic [CNT_W-1:0] high_restart;
    logic [CNT_W:0]   lat_period_w;
    logic [CNT_W-1:0] lat_period;
    logic [CNT_W:0]   two_n;
    logic             p_match;
    logic             h_match;
    logic             sat_hit;
    logic             exp_chg;
    logic             settle_done;

    // Edge position within the ordered stream prev_pos, s_neg, s_pos.
    assign rise_neg = ~prev_pos & s_neg;
    assign rise_pos = ~s_neg & s_pos;
    assign rise     = rise_neg | rise_pos;

    assign per_sum  = {1'b0, per_cnt} + CNT_STEP;
    assign high_sum = {1'b0, high_cnt} + {{CNT_W{1'b0}}, s_neg} + {{CNT_W{1'b0}}, s_pos};
    assign per_adv  = (per_sum  >= {1'b0, CNT_SAT}) ? CNT_SAT : per_sum[CNT_W-1:0];
    assign high_adv = (high_sum >= {1'b0, CNT_SAT}) ? CNT_SAT : high_sum[CNT_W-1:0];

    // The new window starts at the edge sample: an edge in the neg slot owns both
    // samples of the pair (2 counted), an edge in the pos slot owns only s_pos.
    assign per_restart  = {{(CNT_W-2){1'b0}}, rise_neg, rise_pos};
    assign high_restart = {{(CNT_W-2){1'b0}}, rise_neg & s_pos, ~(rise_neg & s_pos)};

    // An edge in the pos slot leaves the s_neg sample (always 0 there) in the old window.
    assign lat_period_w = {1'b0, per_cnt} + {{CNT_W{1'b0}}, rise_pos};
    assign lat_period   = (lat_period_w > {1'b0, CNT_SAT}) ? CNT_SAT : lat_period_w[CNT_W-1:0];

    assign two_n   = {{(CNT_W-4){1'b0}}, exp_mod, 1'b0};
    assign p_match = (lat_period_w == two_n);
    assign h_match = ({1'b0, high_cnt} == {{(CNT_W-3){1'b0}}, exp_mod});

    // An edge landing on the saturating cycle wins over the timeout.
    assign sat_hit     = ~rise & (per_sum >= {1'b0, CNT_SAT});
    assign exp_chg     = (exp_q != exp_mod);
    assign settle_done = (settle_cnt + 8'd1) >= SETTLE_L;

    assign cfg_err   = (exp_mod < 4'd2);
    assign period_ok = period_ok_q & ~cfg_err;
    assign duty_ok   = duty_ok_q & ~cfg_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            per_cnt     <= '0;
            high_cnt    <= '0;
            settle_cnt  <= '0;
            prev_pos    <= 1'b0;
            exp_q       <= '0;
            period_hc   <= '0;
            high_hc     <= '0;
            meas_valid  <= 1'b0;
            period_ok_q <= 1'b0;
            duty_ok_q   <= 1'b0;
            timeout     <= 1'b0;
            err_sticky  <= 1'b0;
        end else begin
            prev_pos   <= s_pos;
            exp_q      <= exp_mod;
            meas_valid <= 1'b0;

            if (rise) begin
                per_cnt  <= per_restart;
                high_cnt <= high_restart;
            end else begin
                per_cnt  <= per_adv;
                high_cnt <= high_adv;
            end

            case (state)
                ST_IDLE: begin
                    if (rise) begin
                        state      <= ST_SETTLE;
                        settle_cnt <= '0;
                    end else if (sat_hit) begin
                        state   <= ST_STALL;
                        timeout <= 1'b1;
                        if (!cfg_err) err_sticky <= 1'b1;
                    end
                end
                ST_SETTLE, ST_MEASURE: begin
                    if (exp_chg) begin
                        // New target: discard settle progress, keep the running window.
                        state      <= ST_SETTLE;
                        settle_cnt <= '0;
                    end else if (rise) begin
                        if (state == ST_SETTLE) begin
                            if (settle_done) begin
                                state <= ST_MEASURE;
                            end else begin
                                settle_cnt <= settle_cnt + 8'd1;
                            end
                        end else begin
                            period_hc   <= lat_period;
                            high_hc     <= high_cnt;
                            meas_valid  <= 1'b1;
                            period_ok_q <= p_match & ~cfg_err;
                            duty_ok_q   <= h_match & ~cfg_err;
                            if (!cfg_err && !(p_match && h_match)) err_sticky <= 1'b1;
                        end
                    end else if (sat_hit) begin
                        state   <= ST_STALL;
                        timeout <= 1'b1;
                        if (!cfg_err) err_sticky <= 1'b1;
                    end
                end
                ST_STALL: begin
                    if (rise) begin
                        state      <= ST_SETTLE;
                        settle_cnt <= '0;
                        timeout    <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_divclk_monitor.sv
// Directed bench for divclk_monitor: a half-cycle divider model drives div_in,
// every comparison goes through chk() against hand-computed values.
module tb_divclk_monitor;
    import divclk_pkg::*;

    logic       clk;
    logic       reset;
    logic       div_in;
    logic [3:0] exp_mod;
    logic [5:0] period_hc;
    logic [5:0] high_hc;
    logic       meas_valid;
    logic       period_ok;
    logic       duty_ok;
    logic       timeout;
    logic       cfg_err;
    logic       err_sticky;

    int n_tests = 0;
    int n_fail  = 0;
    int div_n   = 5;
    bit div_run = 0;
    int ph      = 0;

    divclk_monitor dut (
        .clk        (clk),
        .reset      (reset),
        .div_in     (div_in),
        .exp_mod    (exp_mod),
        .period_hc  (period_hc),
        .high_hc    (high_hc),
        .meas_valid (meas_valid),
        .period_ok  (period_ok),
        .duty_ok    (duty_ok),
        .timeout    (timeout),
        .cfg_err    (cfg_err),
        .err_sticky (err_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Divider model: high for N half-cycles, low for N, updated just after every clk edge.
    initial begin
        div_in = 1'b0;
        forever begin
            @(clk);
            #1;
            if (div_run) begin
                div_in = (ph < div_n);
                ph     = (ph + 1 >= 2 * div_n) ? 0 : ph + 1;
            end else begin
                div_in = 1'b0;
                ph     = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_meas(input int budget, input string tag, output int waited);
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!meas_valid && waited < budget);
        if (!meas_valid) chk({tag, "_timeout"}, {31'd0, meas_valid}, 1);
    endtask

    task automatic do_reset();
        div_run = 0;
        reset   = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        int w;
        reset   = 1'b0;
        exp_mod = 4'd5;
        div_n   = 5;
        repeat (3) @(negedge clk);

        chk("rst_period_hc", period_hc, 0);
        chk("rst_high_hc", high_hc, 0);
        chk("rst_meas_valid", meas_valid, 0);
        chk("rst_ok_bits", {period_ok, duty_ok}, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_sticky", err_sticky, 0);
        chk("rst_state", dut.state, ST_IDLE);

        // N=5, exp 5: 10 half-cycle period, 5 high, a result every 5 clk.
        reset   = 1'b1;
        div_run = 1;
        wait_meas(60, "n5_first", w);
        chk("n5_settle_gap", w >= 14, 1);
        chk("n5_period", period_hc, 10);
        chk("n5_high", high_hc, 5);
        chk("n5_ok", {period_ok, duty_ok}, 2'b11);
        chk("n5_sticky", err_sticky, 0);
        @(negedge clk);
        chk("n5_pulse_width", meas_valid, 0);
        wait_meas(20, "n5_next", w);
        chk("n5_interval", w, 4);

        // Retarget to 6 while measuring: ok bits hold, FSM resettles.
        exp_mod = 4'd6;
        repeat (2) @(negedge clk);
        chk("chg_hold_ok", {period_ok, duty_ok}, 2'b11);
        chk("chg_state", dut.state, ST_SETTLE);
        wait_meas(60, "n5e6", w);
        chk("chg_settle_gap", w >= 10, 1);
        chk("n5e6_period", period_hc, 10);
        chk("n5e6_ok", {period_ok, duty_ok}, 2'b00);
        chk("n5e6_sticky", err_sticky, 1);
        exp_mod = 4'd5;
        wait_meas(60, "n5fix", w);
        chk("n5fix_ok", {period_ok, duty_ok}, 2'b11);
        chk("n5fix_sticky", err_sticky, 1);

        // N=6, exp 6.
        do_reset();
        div_n   = 6;
        exp_mod = 4'd6;
        div_run = 1;
        wait_meas(80, "n6", w);
        chk("n6_period", period_hc, 12);
        chk("n6_high", high_hc, 6);
        chk("n6_ok", {period_ok, duty_ok}, 2'b11);
        chk("n6_sticky", err_sticky, 0);

        // Stall: div_in held low for 40 clk.
        div_run = 0;
        repeat (20) @(negedge clk);
        chk("to_early", timeout, 0);
        repeat (20) @(negedge clk);
        chk("to_set", timeout, 1);
        chk("to_state", dut.state, ST_STALL);
        chk("to_count", dut.per_cnt, 63);
        chk("to_sticky", err_sticky, 1);
        div_run = 1;
        repeat (3) @(negedge clk);
        chk("to_clear", timeout, 0);
        wait_meas(80, "to_restart", w);
        chk("to_settle_gap", w >= 14, 1);
        chk("to_restart_period", period_hc, 12);

        // exp_mod=1 with a divide-by-1 stream: raw compare would match, outputs forced low.
        do_reset();
        div_n   = 1;
        exp_mod = 4'd1;
        div_run = 1;
        @(negedge clk);
        chk("cfg1_err", cfg_err, 1);
        wait_meas(40, "cfg1", w);
        chk("cfg1_period", period_hc, 2);
        chk("cfg1_high", high_hc, 1);
        chk("cfg1_ok", {period_ok, duty_ok}, 2'b00);

        // exp_mod=0 against N=5: mismatching results must not set the sticky flag.
        do_reset();
        div_n   = 5;
        exp_mod = 4'd0;
        div_run = 1;
        wait_meas(60, "cfg0", w);
        chk("cfg0_err", cfg_err, 1);
        chk("cfg0_ok", {period_ok, duty_ok}, 2'b00);
        chk("cfg0_sticky", err_sticky, 0);

        // Reset mid-period with the divider still running.
        exp_mod = 4'd5;
        wait_meas(60, "pre_rst", w);
        chk("pre_rst_ok", {period_ok, duty_ok}, 2'b11);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mid_rst_outputs", {period_hc, high_hc, meas_valid, period_ok, duty_ok, timeout, err_sticky}, 0);
        chk("mid_rst_state", dut.state, ST_IDLE);
        repeat (3) @(negedge clk);
        chk("mid_rst_no_pulse", meas_valid, 0);
        reset = 1'b1;
        wait_meas(60, "post_rst", w);
        chk("post_rst_gap", w >= 12, 1);
        chk("post_rst_period", period_hc, 10);
        chk("post_rst_high", high_hc, 5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
